// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle integer divider: FSM encoding,
// divide-by-zero result constant and the operand magnitude helper.
package div_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_RUN  = 2'd2,
        S_FIX  = 2'd3
    } div_state_t;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    // Two's complement magnitude; -2^31 maps onto 0x8000_0000 read as unsigned.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic sgn);
        return (sgn && value[31]) ? -value : value;
    endfunction

endpackage

// File: rtl/clz.sv
// Leading-zero counter over a 32-bit word; an all-zero input yields 32.
module clz (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // NOTE: every variable written in always_comb gets a default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) count = 6'(31 - i);
        end
    end

endmodule

// File: rtl/div_unit.sv
// Restoring shift-subtract divider for DIV/DIVU: one quotient bit per cycle,
// with leading zeros of the dividend skipped up front using clz.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ITER_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t state, state_nxt;

    logic              sgn_mode;
    logic [WIDTH-1:0]  a_raw, b_raw;
    logic [WIDTH-1:0]  abs_a, abs_b;
    logic [WIDTH-1:0]  r_acc, a_sh, q_acc;
    logic [ITER_W-1:0] n_cnt, lz, n_prep;
    logic              dbz;
    logic              sa, sb;
    logic [WIDTH:0]    r_shift;
    logic [WIDTH-1:0]  r_sub;
    logic              r_ge;

    assign abs_a  = magnitude(a_raw, sgn_mode);
    assign abs_b  = magnitude(b_raw, sgn_mode);
    assign sa     = sgn_mode & a_raw[WIDTH-1];
    assign sb     = sgn_mode & b_raw[WIDTH-1];
    assign n_prep = ITER_W'(WIDTH) - lz;

    clz u_clz (
        .value (abs_a),
        .count (lz)
    );

    // The shifted remainder is WIDTH+1 bits wide; the difference always fits
    // back into WIDTH bits whenever it is taken.
    assign r_shift = {r_acc, a_sh[WIDTH-1]};
    assign r_ge    = (r_shift >= {1'b0, abs_b});
    assign r_sub   = r_shift[WIDTH-1:0] - abs_b;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_PREP;
            S_PREP: begin
                if (b_raw == '0 || lz == ITER_W'(WIDTH)) state_nxt = S_FIX;
                else                                     state_nxt = S_RUN;
            end
            S_RUN:  if (n_cnt == ITER_W'(1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            sgn_mode    <= 1'b0;
            a_raw       <= '0;
            b_raw       <= '0;
            r_acc       <= '0;
            a_sh        <= '0;
            q_acc       <= '0;
            n_cnt       <= '0;
            dbz         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_raw       <= dividend;
                        b_raw       <= divisor;
                        sgn_mode    <= is_signed;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end
                end
                S_PREP: begin
                    r_acc <= '0;
                    q_acc <= '0;
                    a_sh  <= abs_a << lz;
                    n_cnt <= n_prep;
                    dbz   <= (b_raw == '0);
                end
                S_RUN: begin
                    a_sh  <= a_sh << 1;
                    r_acc <= r_ge ? r_sub : r_shift[WIDTH-1:0];
                    q_acc <= {q_acc[WIDTH-2:0], r_ge};
                    n_cnt <= n_cnt - ITER_W'(1);
                end
                S_FIX: begin
                    if (dbz) begin
                        quotient    <= DIV_BY_ZERO_Q;
                        remainder   <= a_raw;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient  <= (sa ^ sb) ? -q_acc : q_acc;
                        remainder <= sa ? -r_acc : r_acc;
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed plan vectors, randomized
// operations against an arithmetic reference model, and handshake corners.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          sg;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        int          lat;
    } vec_t;

    // Reference: plain 64-bit arithmetic (truncating division) plus the
    // cycle count implied by the significant-bit length of |dividend|.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sg,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output bit dz, output int lat);
        longint sa, sb, mag;
        int n;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 2;
            return;
        end
        dz = 1'b0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        mag = (sa < 0) ? -sa : sa;
        n = 0;
        while (mag > 0) begin
            mag = mag >> 1;
            n++;
        end
        lat = n + 2;
    endfunction

    // Issues one operation at the current negedge. lat is the number of edges
    // after the accepting edge until done is seen, -1 on timeout. Optionally
    // pulses start with junk operands after `inject` cycles.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sg,
                          input int inject, output int lat, output logic busy0);
        start = 1'b1; dividend = a; divisor = b; is_signed = sg;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (k == inject) begin
                start = 1'b1; dividend = 32'h1234_5678; divisor = 32'd3; is_signed = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 0 || remainder !== 0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b dbz=%b q=%h r=%h, expected all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        vec_t v[7];
        int lat;
        logic busy0;
        v[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 9};
        v[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 5};
        v[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 5};
        v[3] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 34};
        v[4] = '{32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          1'b0, 2};
        v[5] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1, 2};
        v[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 34};
        for (int i = 0; i < 7; i++) begin
            run_op(v[i].a, v[i].b, v[i].sg, 0, lat, busy0);
            checks++;
            if (busy0 !== 1'b1) begin
                failures++;
                $display("FAIL directed[%0d] busy: got %b, expected 1", i, busy0);
            end
            checks++;
            if (lat !== v[i].lat) begin
                failures++;
                $display("FAIL directed[%0d] latency: got %0d, expected %0d", i, lat, v[i].lat);
            end
            checks++;
            if (quotient !== v[i].q || remainder !== v[i].r || div_by_zero !== v[i].dz) begin
                failures++;
                $display("FAIL directed[%0d] result: q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                         i, quotient, remainder, div_by_zero, v[i].q, v[i].r, v[i].dz);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || quotient !== v[i].q || remainder !== v[i].r) begin
                failures++;
                $display("FAIL directed[%0d] hold: done=%b busy=%b q=%h r=%h, expected 0 0 %h %h",
                         i, done, busy, quotient, remainder, v[i].q, v[i].r);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, eq, er;
        bit sg, edz;
        int elat, lat;
        logic busy0;
        for (int i = 0; i < 40; i++) begin
            a  = $urandom() >> $urandom_range(0, 31);
            b  = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) b = 0;
            if ($urandom_range(0, 9) == 0) a = 0;
            sg = 1'($urandom_range(0, 1));
            if (sg && $urandom_range(0, 1) == 1) a = -a;
            if (sg && $urandom_range(0, 1) == 1) b = -b;
            model(a, b, sg, eq, er, edz, elat);
            run_op(a, b, sg, 0, lat, busy0);
            checks++;
            if (lat !== elat || quotient !== eq || remainder !== er || div_by_zero !== edz) begin
                failures++;
                $display("FAIL random[%0d] %h/%h s=%0d: lat=%0d q=%h r=%h dbz=%b, expected lat=%0d q=%h r=%h dbz=%b",
                         i, a, b, sg, lat, quotient, remainder, div_by_zero, elat, eq, er, edz);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_busy_start();
        logic [31:0] eq, er;
        bit edz;
        int elat, lat;
        logic busy0;
        model(32'hDEAD_BEEF, 32'd13, 1'b0, eq, er, edz, elat);
        run_op(32'hDEAD_BEEF, 32'd13, 1'b0, 4, lat, busy0);
        checks++;
        if (lat !== elat || quotient !== eq || remainder !== er) begin
            failures++;
            $display("FAIL busy_start: lat=%0d q=%h r=%h, expected lat=%0d q=%h r=%h",
                     lat, quotient, remainder, elat, eq, er);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start idle: busy=%b, expected 0 (ignored start was queued)", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eq, er;
        bit edz;
        int elat, lat;
        logic busy0;
        run_op(32'd1000, 32'd0, 1'b0, 0, lat, busy0);
        checks++;
        if (done !== 1'b1 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL b2b first: done=%b dbz=%b, expected 1 1", done, div_by_zero);
        end
        model(32'hFFFF_FC18, 32'd9, 1'b1, eq, er, edz, elat);
        run_op(32'hFFFF_FC18, 32'd9, 1'b1, 0, lat, busy0);
        checks++;
        if (busy0 !== 1'b1 || lat !== elat || quotient !== eq || remainder !== er || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL b2b second: busy0=%b lat=%0d q=%h r=%h dbz=%b, expected 1 %0d %h %h 0",
                     busy0, lat, quotient, remainder, div_by_zero, elat, eq, er);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int late = 0;
        start = 1'b1; dividend = 32'hFFFF_0000; divisor = 32'd7; is_signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 0 || remainder !== 0) begin
            failures++;
            $display("FAIL reset_mid_run: busy=%b done=%b dbz=%b q=%h r=%h, expected all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) late++;
        end
        checks++;
        if (late !== 0) begin
            failures++;
            $display("FAIL reset_mid_run late activity: %0d cycles with done/busy, expected 0", late);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the DIV/DIVU instructions.
- Sits downstream of the leading-zero counter `clz` and consumes its count to skip leading-zero iterations.
- Restoring shift-subtract datapath, one quotient bit per cycle.
- Controlled from the execute stage by a start/busy/done handshake; quotient and remainder feed the LO/HI registers.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported (fixed by `clz`).
- ITER_W, 6, width of the iteration counter (holds 0..32).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; captured with start.
- dividend  in  32  captured with start.
- divisor  in  32  captured with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  single-cycle completion pulse.
- quotient  out  32  to LO; held until the next completion.
- remainder  out  32  to HI; held until the next completion.
- div_by_zero  out  1  qualifies quotient/remainder in the done cycle.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0.
  - Reset takes effect from any state, so an in-flight operation is abandoned with no done pulse.
- States: IDLE, PREP, RUN, FIX.
- IDLE:
  - start=1 captures the operands and is_signed; busy<=1; go to PREP.
  - start=0: stay.
  - done is cleared every cycle it is not being set.
- PREP:
  - Form |a| and |b| (unsigned mode uses raw values); |-2^31| = 0x8000_0000 as unsigned.
  - Drive |a| into the `clz` instance to get z (0..32).
  - Remainder accumulator R<=0; shift register A<=|a|<<z (z=32 gives 0); counter n<=32-z.
  - Divisor==0: set div_by_zero flag and go to FIX, skipping RUN.
  - n==0 (dividend zero): go to FIX.
  - Otherwise go to RUN.
- RUN, one edge per iteration:
  - {R,A}<={R,A}<<1.
  - If the shifted R >= |b|: R<=R-|b| and set Q LSB=1; else set Q LSB=0. Q shifts in from the LSB.
  - R compare/subtract is 33 bits wide to avoid overflow.
  - n<=n-1; go to FIX when n reaches 0 on this edge.
- FIX:
  - Signed mode: quotient = (sa^sb) ? -Q : Q; remainder = sa ? -R : R.
  - Divide-by-zero: quotient=32'hFFFF_FFFF, remainder=dividend (raw captured value), div_by_zero=1.
  - done<=1, busy<=0, go to IDLE.
- Latency: with the start-sampling edge as edge 0, done is visible after edge n+2.
  - Range: 2 cycles (zero dividend or divisor) to 34 cycles (z=0).
- start while busy: ignored, no queuing.
- start in the done cycle: accepted, since state is already IDLE.
- Overflow: -2^31 / -1 signed gives quotient 0x8000_0000, remainder 0 (wraps naturally).
- Results are stable from the done cycle until the next FIX edge.
- div_by_zero is cleared at the next accepted start.

Decomposition:
- Shared header/package:
  - state encodings (IDLE=2'd0, PREP=2'd1, RUN=2'd2, FIX=2'd3);
  - DIV_BY_ZERO_Q constant 32'hFFFF_FFFF.
- One sub-module: instantiate the existing `clz` combinationally on |a| in PREP.
- Everything else stays in div_unit.

Test Plan:
- DIVU 100/7 -> z=25, done 9 cycles after start; quotient=14, remainder=2, div_by_zero=0.
- DIV -7/2 -> quotient=0xFFFF_FFFD (-3), remainder=0xFFFF_FFFF (-1); DIV 7/-2 -> quotient=-3, remainder=1.
- DIVU 0xFFFF_FFFF/1 -> done 34 cycles after start, quotient=0xFFFF_FFFF, remainder=0.
- DIVU 0/5 -> done after 2 cycles, quotient=0, remainder=0.
- DIVU 5/0 -> done after 2 cycles, quotient=0xFFFF_FFFF, remainder=5, div_by_zero=1.
- DIV 0x8000_0000/0xFFFF_FFFF -> quotient=0x8000_0000, remainder=0.
- Protocol:
  - A start pulse while busy has no effect on the results.
  - Back-to-back start in the done cycle runs the second operation correctly.
  - rst_n=0 mid-RUN gives busy=0, done=0, quotient=0, remainder=0 next cycle, and no late done pulse.
